rns_sub_pipe: RTL and testbench

- Parametrised, pipelined residue-number-system modular subtractor: NCH independent channels, each computing (a_i - b_i) mod m_i, or (b_i - a_i) mod m_i in swap mode.
- Successor to the fixed three-channel, 3-bit combinational subtractor in the RNS datapath.
- Adds runtime-programmable moduli, valid/ready flow control with backpressure, a 2-cycle pipeline and per-channel range-error reporting.
- Sits between the forward converter and the reverse converter / accumulator.

---
 rtl/rns_sub_pipe.sv | 89 ++++++++
 tb/tb_rns_sub_pipe.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/rns_sub_pipe.sv
// Pipelined RNS modular subtractor: NCH channels of (x - y) mod m_i with
// runtime moduli, valid/ready flow control and per-channel range errors.
module rns_sub_pipe #(
  parameter int unsigned      NCH      = 3,
  parameter int unsigned      W        = 3,
  parameter logic [NCH*W-1:0] MOD_INIT = {3'd3, 3'd5, 3'd7}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mod_load,
  input  logic [NCH*W-1:0]   mod_in,
  output logic               busy,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_swap,
  input  logic [NCH*W-1:0]   in_a,
  input  logic [NCH*W-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NCH*W-1:0]   out_res,
  output logic [NCH-1:0]     out_err
);

  logic [NCH*W-1:0] mods;
  logic             s1_valid;
  logic [W:0]       s1_d [NCH];
  logic [NCH-1:0]   s1_err;

  logic             s2_adv;
  logic             accept;
  logic             mod_we;

  logic [W-1:0]     x     [NCH];
  logic [W-1:0]     y     [NCH];
  logic [W-1:0]     m     [NCH];
  logic [W:0]       d_nxt [NCH];
  logic [W-1:0]     wrap  [NCH];
  logic [NCH-1:0]   err_nxt;
  logic [NCH*W-1:0] res_nxt;

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;
  assign accept   = in_valid && in_ready;
  assign busy     = s1_valid || out_valid;
  // Moduli may only change with an empty pipe, so both stages can read mods directly.
  assign mod_we   = mod_load && !busy && !accept;

  always_comb begin
    err_nxt = '0;
    res_nxt = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      m[i]     = mods[i*W +: W];
      x[i]     = in_swap ? in_b[i*W +: W] : in_a[i*W +: W];
      y[i]     = in_swap ? in_a[i*W +: W] : in_b[i*W +: W];
      d_nxt[i] = {1'b0, x[i]} - {1'b0, y[i]};
      err_nxt[i] = (x[i] >= m[i]) || (y[i] >= m[i]) || (m[i] < W'(2));
      // On borrow the low W bits hold x-y+2^W; adding m and truncating yields x-y+m.
      wrap[i]  = s1_d[i][W-1:0] + m[i];
      res_nxt[i*W +: W] = s1_err[i] ? '0 : (s1_d[i][W] ? wrap[i] : s1_d[i][W-1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mods      <= MOD_INIT;
      s1_valid  <= 1'b0;
      s1_d      <= '{default: '0};
      s1_err    <= '0;
      out_valid <= 1'b0;
      out_res   <= '0;
      out_err   <= '0;
    end else begin
      if (mod_we)
        mods <= mod_in;
      if (accept) begin
        s1_d   <= d_nxt;
        s1_err <= err_nxt;
      end
      if (in_ready)
        s1_valid <= accept;
      if (s2_adv) begin
        out_valid <= s1_valid;
        out_res   <= res_nxt;
        out_err   <= s1_err;
      end
    end
  end

endmodule

// File: tb/tb_rns_sub_pipe.sv
// Directed bench for rns_sub_pipe: residue tuples are written (ch0, ch1, ch2).
module tb_rns_sub_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       mod_load;
  logic [8:0] mod_in;
  logic       busy;
  logic       in_valid;
  logic       in_ready;
  logic       in_swap;
  logic [8:0] in_a;
  logic [8:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] out_res;
  logic [2:0] out_err;

  int checks   = 0;
  int failures = 0;

  rns_sub_pipe #(.NCH(3), .W(3), .MOD_INIT({3'd3, 3'd5, 3'd7})) dut (
    .clk(clk), .rst(rst), .mod_load(mod_load), .mod_in(mod_in), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_swap(in_swap),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_err(out_err)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] pk(input logic [2:0] c0, input logic [2:0] c1,
                                    input logic [2:0] c2);
    return {c2, c1, c0};
  endfunction

  task automatic test_reset();
    rst = 1'b1; mod_load = 1'b0; mod_in = '0; in_valid = 1'b0; in_swap = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_res !== 9'h000) begin failures++; $display("FAIL reset_out_res got=%h exp=000", out_res); end
    checks++; if (out_err !== 3'b000) begin failures++; $display("FAIL reset_out_err got=%b exp=000", out_err); end
  endtask

  task automatic test_basic();
    @(posedge clk); #1;
    in_a = pk(2, 4, 1); in_b = pk(5, 1, 2); in_swap = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL basic_stage1 got valid=%b busy=%b exp valid=0 busy=1", out_valid, busy); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_latency got=%b exp=1", out_valid); end
    checks++; if (out_res !== pk(4, 3, 2)) begin failures++; $display("FAIL basic_res got=%h exp=%h", out_res, pk(4, 3, 2)); end
    checks++; if (out_err !== 3'b000) begin failures++; $display("FAIL basic_err got=%b exp=000", out_err); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL basic_drain got valid=%b busy=%b exp 0 0", out_valid, busy); end
  endtask

  task automatic test_swap();
    @(posedge clk); #1;
    in_a = pk(2, 4, 1); in_b = pk(5, 1, 2); in_swap = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0; in_swap = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL swap_valid got=%b exp=1", out_valid); end
    checks++; if (out_res !== pk(3, 2, 1)) begin failures++; $display("FAIL swap_res got=%h exp=%h", out_res, pk(3, 2, 1)); end
    checks++; if (out_err !== 3'b000) begin failures++; $display("FAIL swap_err got=%b exp=000", out_err); end
  endtask

  task automatic test_range_modload();
    @(posedge clk); #1;
    mod_load = 1'b1; mod_in = pk(7, 5, 4);
    @(posedge clk); #1 mod_load = 1'b0;
    in_a = pk(6, 5, 3); in_b = pk(0, 0, 3); in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL range_valid got=%b exp=1", out_valid); end
    checks++; if (out_res !== pk(6, 0, 0)) begin failures++; $display("FAIL range_res got=%h exp=%h", out_res, pk(6, 0, 0)); end
    checks++; if (out_err !== 3'b010) begin failures++; $display("FAIL range_err got=%b exp=010", out_err); end
    // ch2 modulus is now 4: 0-1 wraps to 3
    @(posedge clk); #1;
    in_a = pk(0, 0, 0); in_b = pk(1, 1, 1); in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_res !== pk(6, 4, 3) || out_err !== 3'b000) begin failures++; $display("FAIL newmod_res got=%h/%b exp=%h/000", out_res, out_err, pk(6, 4, 3)); end
  endtask

  task automatic test_backpressure();
    logic [8:0] ta [4];
    logic [8:0] tb [4];
    logic       ts [4];
    logic [8:0] exp [4];
    logic [8:0] held;
    logic       held_valid;
    int         tx, rx, cyc;
    ta[0] = pk(1, 2, 3); tb[0] = pk(0, 0, 0); ts[0] = 1'b0; exp[0] = pk(1, 2, 3);
    ta[1] = pk(0, 0, 0); tb[1] = pk(1, 1, 1); ts[1] = 1'b0; exp[1] = pk(6, 4, 3);
    ta[2] = pk(6, 4, 2); tb[2] = pk(3, 4, 3); ts[2] = 1'b0; exp[2] = pk(3, 0, 3);
    ta[3] = pk(5, 3, 1); tb[3] = pk(6, 1, 0); ts[3] = 1'b1; exp[3] = pk(1, 3, 3);
    tx = 0; rx = 0; cyc = 0; held = '0; held_valid = 1'b0;
    while (rx < 4 && cyc < 40) begin
      @(posedge clk); #1;
      out_ready = !(cyc >= 3 && cyc <= 5);
      in_valid  = (tx < 4);
      if (tx < 4) begin in_a = ta[tx]; in_b = tb[tx]; in_swap = ts[tx]; end
      @(negedge clk);
      if (held_valid) begin
        checks++;
        if (out_valid !== 1'b1 || out_res !== held) begin failures++; $display("FAIL bp_hold cyc=%0d got=%b/%h exp=1/%h", cyc, out_valid, out_res, held); end
      end
      if (cyc >= 3 && cyc <= 5) begin
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", cyc, in_ready); end
      end
      held_valid = out_valid && !out_ready;
      held = out_res;
      if (out_valid && out_ready) begin
        checks++;
        if (out_res !== exp[rx]) begin failures++; $display("FAIL bp_res idx=%0d got=%h exp=%h", rx, out_res, exp[rx]); end
        rx++;
      end
      if (in_valid && in_ready) tx++;
      cyc++;
    end
    in_valid = 1'b0; in_swap = 1'b0; out_ready = 1'b1;
    checks++; if (rx != 4 || cyc != 9) begin failures++; $display("FAIL bp_count got rx=%0d cyc=%0d exp rx=4 cyc=9", rx, cyc); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL bp_no_dup got valid=%b busy=%b exp 0 0", out_valid, busy); end
  endtask

  task automatic test_reset_midflight();
    int seen;
    @(posedge clk); #1;
    out_ready = 1'b0; in_a = pk(1, 1, 1); in_b = pk(0, 0, 0); in_valid = 1'b1;
    @(posedge clk); #1 in_a = pk(2, 2, 2);
    @(posedge clk); #1 in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL mid_full got valid=%b ready=%b exp 1 0", out_valid, in_ready); end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mid_reset got valid=%b busy=%b exp 0 0", out_valid, busy); end
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL mid_ghost got=%0d exp=0", seen); end
    // ch2 back to modulus 3: 0-1 gives 2
    in_a = pk(0, 0, 0); in_b = pk(1, 1, 1); in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_res !== pk(6, 4, 2)) begin failures++; $display("FAIL mid_moduli got=%b/%h exp=1/%h", out_valid, out_res, pk(6, 4, 2)); end
  endtask

  task automatic test_modload_busy();
    @(posedge clk); #1;
    in_a = pk(3, 3, 2); in_b = pk(1, 1, 1); in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    mod_load = 1'b1; mod_in = pk(7, 5, 4);
    @(posedge clk); #1 mod_load = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_res !== pk(2, 2, 1)) begin failures++; $display("FAIL busy_first got=%b/%h exp=1/%h", out_valid, out_res, pk(2, 2, 1)); end
    @(posedge clk); #1;
    in_a = pk(0, 0, 0); in_b = pk(1, 1, 1); in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_res !== pk(6, 4, 2)) begin failures++; $display("FAIL busy_ignored got=%h exp=%h", out_res, pk(6, 4, 2)); end
    // load coinciding with an accept while idle is dropped too
    @(posedge clk); #1;
    mod_load = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1 mod_load = 1'b0;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL coincide_accept got valid=%b busy=%b exp 0 1", out_valid, busy); end
    @(posedge clk); #1 in_valid = 1'b0;
    checks++; if (out_res !== pk(6, 4, 2)) begin failures++; $display("FAIL coincide_beat got=%h exp=%h", out_res, pk(6, 4, 2)); end
    @(posedge clk); #1;
    checks++; if (out_res !== pk(6, 4, 2)) begin failures++; $display("FAIL coincide_dropped got=%h exp=%h", out_res, pk(6, 4, 2)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_swap();
    test_range_modload();
    test_backpressure();
    test_reset_midflight();
    test_modload_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
